// File: rtl/acs_pkg.sv
// Shared constants for the adder result collector: default word size and FSM encoding.
package acs_pkg;

   localparam int NIBBLES_DEF = 4;

   localparam logic ST_COLLECT = 1'b0;
   localparam logic ST_HOLD    = 1'b1;

   // Index width for a mod-n counter; a 1-bit floor keeps n=1 from producing a zero-width vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/acs_nibble_counter.sv
// Mod-N slot counter with enable, synchronous clear (clear wins) and terminal-count flag.
module acs_nibble_counter
   import acs_pkg::*;
#(
   parameter int N = NIBBLES_DEF,
   parameter int W = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc  = (cnt_q == W'(N - 1));
   assign cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/acs_result_collector.sv
// Assembles NIBBLES successive 4-bit adder results into one word, feeding the carry back
// to the adder between nibbles and holding the finished word until the consumer takes it.
//
// state      | meaning
// ST_COLLECT | accepting nibbles (in_ready=1, out_valid=0)
// ST_HOLD    | finished word presented (in_ready=0, out_valid=1)
module acs_result_collector
   import acs_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           s,
   input  logic                 c,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 cin_fb,
   input  logic                 flush,
   output logic [4*NIBBLES-1:0] word,
   output logic                 cout,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int IDX_W = idx_width(NIBBLES);

   logic                 state_q;
   logic                 state_d;
   logic [4*NIBBLES-1:0] word_q;
   logic [4*NIBBLES-1:0] word_d;
   logic                 cout_q;
   logic                 cout_d;
   logic                 cin_fb_q;
   logic                 cin_fb_d;

   logic [IDX_W-1:0]     idx;
   logic                 idx_last;
   logic                 collecting;
   logic                 flush_hit;
   logic                 accept;

   assign collecting = (state_q == ST_COLLECT);
   // Flush only matters while collecting and beats a simultaneous accept.
   assign flush_hit  = collecting && flush;
   assign accept     = collecting && in_valid && !flush;

   acs_nibble_counter #(
      .N (NIBBLES),
      .W (IDX_W)
   ) u_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .clr   (flush_hit),
      .cnt   (idx),
      .tc    (idx_last)
   );

   always_comb begin
      word_d = word_q;
      if (accept) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
               word_d[4*i +: 4] = s;
            end
         end
      end
   end

   always_comb begin
      cin_fb_d = cin_fb_q;
      cout_d   = cout_q;
      state_d  = state_q;
      if (flush_hit) begin
         cin_fb_d = 1'b0;
      end else if (accept) begin
         if (idx_last) begin
            cin_fb_d = 1'b0;
            cout_d   = c;
            state_d  = ST_HOLD;
         end else begin
            cin_fb_d = c;
         end
      end
      // No bypass: a taken word always costs one cycle back in ST_COLLECT.
      if (state_q == ST_HOLD && out_ready) begin
         state_d = ST_COLLECT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_COLLECT;
         word_q   <= '0;
         cout_q   <= 1'b0;
         cin_fb_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         cout_q   <= cout_d;
         cin_fb_q <= cin_fb_d;
      end
   end

   assign in_ready  = collecting;
   assign out_valid = (state_q == ST_HOLD);
   assign word      = word_q;
   assign cout      = cout_q;
   assign cin_fb    = cin_fb_q;

endmodule

// File: tb/tb_acs_result_collector.sv
// Self-checking bench for acs_result_collector: directed table, hand sequences and a
// randomized run against a nibble-list reference model; a second NIBBLES=2 instance.
module tb_acs_result_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  s;
   logic        c, in_valid, flush, out_ready;
   logic        in_ready, cin_fb, cout, out_valid;
   logic [15:0] word;

   logic [3:0]  s2;
   logic        c2, in_valid2, flush2, out_ready2;
   logic        in_ready2, cin_fb2, cout2, out_valid2;
   logic [7:0]  word2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   acs_result_collector #(.NIBBLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .c(c), .in_valid(in_valid), .in_ready(in_ready),
      .cin_fb(cin_fb), .flush(flush), .word(word), .cout(cout), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   acs_result_collector #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .s(s2), .c(c2), .in_valid(in_valid2), .in_ready(in_ready2),
      .cin_fb(cin_fb2), .flush(flush2), .word(word2), .cout(cout2), .out_valid(out_valid2),
      .out_ready(out_ready2)
   );

   // Reference model: a running word, a count of nibbles gathered, and a hold flag.
   logic        m_hold;
   int          m_cnt;
   logic [15:0] m_word;
   logic        m_cout, m_cin;

   task automatic model_reset();
      m_hold = 1'b0; m_cnt = 0; m_word = '0; m_cout = 1'b0; m_cin = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] sv, input logic cv,
                             input logic f, input logic r);
      if (m_hold) begin
         if (r) m_hold = 1'b0;
      end else if (f) begin
         m_cnt = 0;
         m_cin = 1'b0;
      end else if (v) begin
         m_word = (m_word & ~(16'hF << (4 * m_cnt))) | (16'(sv) << (4 * m_cnt));
         m_cnt++;
         if (m_cnt == 4) begin
            m_cnt  = 0;
            m_cout = cv;
            m_cin  = 1'b0;
            m_hold = 1'b1;
         end else begin
            m_cin = cv;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " word"},      32'(word),      32'(m_word));
      chk({tag, " cout"},      32'(cout),      32'(m_cout));
      chk({tag, " cin_fb"},    32'(cin_fb),    32'(m_cin));
      chk({tag, " in_ready"},  32'(in_ready),  32'(!m_hold));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(m_hold));
   endtask

   // One clock: check current outputs against the model, drive, clock, advance the model.
   task automatic cyc(input string tag, input logic v, input logic [3:0] sv, input logic cv,
                      input logic f, input logic r);
      @(negedge clk);
      check_model(tag);
      in_valid = v; s = sv; c = cv; flush = f; out_ready = r;
      @(posedge clk);
      model_step(v, sv, cv, f, r);
   endtask

   typedef struct {
      logic       v;
      logic [3:0] s;
      logic       c;
      logic       f;
      logic       r;
      logic [15:0] w;
      logic       co;
      logic       ov;
      logic       ir;
      logic       cin;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // basic word, then a held word overwriting an old one, flush/valid ignored while held
      tbl.push_back('{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 16'h0FA5, 1'b0, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1FA5, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1FA5, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h1FA2, 1'b0, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 16'h1F42, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 16'h1642, 1'b0, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'h3642, 1'b1, 1'b1, 1'b0, 1'b0});
      for (int k = 0; k < 5; k++)
         tbl.push_back('{1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 16'h3642, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 16'h3642, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h3642, 1'b1, 1'b0, 1'b1, 1'b0});

      rst_n = 1'b0;
      in_valid = 1'b0; s = '0; c = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; s2 = '0; c2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset word",      32'(word),      32'h0);
      chk("reset cout",      32'(cout),      32'h0);
      chk("reset cin_fb",    32'(cin_fb),    32'h0);
      chk("reset in_ready",  32'(in_ready),  32'h1);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         in_valid = tbl[i].v; s = tbl[i].s; c = tbl[i].c; flush = tbl[i].f; out_ready = tbl[i].r;
         @(posedge clk);
         model_step(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].f, tbl[i].r);
         #1;
         chk($sformatf("tbl%0d word", i),      32'(word),      32'(tbl[i].w));
         chk($sformatf("tbl%0d cout", i),      32'(cout),      32'(tbl[i].co));
         chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("tbl%0d in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
         chk($sformatf("tbl%0d cin_fb", i),    32'(cin_fb),    32'(tbl[i].cin));
      end

      // flush after two nibbles, with a nibble offered on the flush cycle
      cyc("fl", 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
      cyc("fl", 1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
      cyc("fl", 1'b1, 4'hE, 1'b1, 1'b1, 1'b0);
      cyc("fl", 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
      cyc("fl", 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
      cyc("fl", 1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
      cyc("fl", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("flush word", 32'(word), 32'h2DCB);
      chk("flush out_valid", 32'(out_valid), 32'h1);
      cyc("fl", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

      // asynchronous reset between edges, mid-word with cin_fb=1
      cyc("ar", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      cyc("ar", 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async word",      32'(word),      32'h0);
      chk("async cout",      32'(cout),      32'h0);
      chk("async cin_fb",    32'(cin_fb),    32'h0);
      chk("async in_ready",  32'(in_ready),  32'h1);
      chk("async out_valid", 32'(out_valid), 32'h0);
      model_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      cyc("ar", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
      cyc("ar", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
      cyc("ar", 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      cyc("ar", 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("async word after 4", 32'(word), 32'h4321);
      cyc("ar", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

      // in_valid toggling every other cycle
      for (int i = 0; i < 8; i++)
         cyc("tg", 1'(i % 2), 4'(i + 3), 1'(i % 3 == 0), 1'b0, 1'b0);
      @(negedge clk);
      chk("toggle word", 32'(word), 32'hA864);
      cyc("tg", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++)
         cyc("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 1)));
      @(negedge clk);
      check_model("rnd end");

      // NIBBLES=2 instance
      @(negedge clk);
      in_valid2 = 1'b1; s2 = 4'hF; c2 = 1'b1;
      @(posedge clk); #1;
      chk("n2 cin_fb first",  32'(cin_fb2),    32'h1);
      chk("n2 out_valid first", 32'(out_valid2), 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      chk("n2 word",      32'(word2),      32'hFF);
      chk("n2 cout",      32'(cout2),      32'h1);
      chk("n2 out_valid", 32'(out_valid2), 32'h1);
      chk("n2 cin_fb",    32'(cin_fb2),    32'h0);
      @(negedge clk);
      in_valid2 = 1'b0; out_ready2 = 1'b1;
      @(posedge clk); #1;
      chk("n2 drained", 32'(out_valid2), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acs_result_collector.md
ACS_RESULT_COLLECTOR -- requirements
Module: acs_result_collector

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit adder results assembled into one output word (legal range 2..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port s  input  4  sum nibble from the 4-bit adder.
REQ-005 SHALL have port c  input  1  carry-out from the 4-bit adder.
REQ-006 SHALL have port in_valid  input  1  s/c hold a valid nibble result.
REQ-007 SHALL have port in_ready  output  1  collector accepts a nibble this cycle.
REQ-008 SHALL have port cin_fb  output  1  registered carry fed back to the adder cin for the next nibble.
REQ-009 SHALL have port flush  input  1  synchronous discard of the partial word.
REQ-010 SHALL have port word  output  4*NIBBLES  assembled sum, nibble 0 at bits [3:0].
REQ-011 SHALL have port cout  output  1  carry-out of the most significant nibble.
REQ-012 SHALL have port out_valid  output  1  word/cout valid.
REQ-013 SHALL have port out_ready  input  1  consumer takes word this cycle.

Function
REQ-014 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL accept a nibble when in_valid && in_ready, writing s into word slot idx (bits 4*idx+3..4*idx), LSB-first.
REQ-016 SHALL keep a nibble index idx (width clog2(NIBBLES)) incremented on each accept and wrapped to 0 after slot NIBBLES-1.
REQ-017 SHALL register cin_fb <= c on accepting any nibble except the last; on accepting the last, cin_fb <= 0.
REQ-018 SHALL, on accepting slot NIBBLES-1, register cout <= c and move to HOLD the next cycle (word valid 1 cycle after last accept).
REQ-019 SHALL hold word, cout, out_valid stable in HOLD until out_valid && out_ready, then return to COLLECT next cycle (one-cycle bubble, no bypass).
REQ-020 SHALL leave word and cout unchanged after leaving HOLD until overwritten by new accepts; cout updates only on last-slot accept.
REQ-021 SHALL, on flush=1 in COLLECT, set idx=0 and cin_fb=0, ignoring any simultaneous accept (flush wins).
REQ-022 SHALL ignore flush in HOLD (a completed word is never discarded).
REQ-023 SHALL ignore s/c whenever in_ready=0, regardless of in_valid.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state=COLLECT, idx=0, word=0, cout=0, cin_fb=0; hence in_ready=1, out_valid=0.
REQ-025 SHALL abandon any partial or held word on reset mid-operation; first accept after release goes to slot 0.
REQ-026 SHALL leave all outputs as combinational functions of registers only (no input-to-output paths).

Structure
REQ-027 SHALL take NIBBLES default and the FSM state encoding (COLLECT=0, HOLD=1) from shared package acs_pkg.
REQ-028 SHALL instantiate one sub-module, acs_nibble_counter (mod-NIBBLES counter with enable, sync clear, terminal-count output), for idx.

Verification
REQ-029 SHALL cover: reset, then nibbles (s,c)=(5,0),(A,0),(F,1),(1,0) with in_valid=1, out_ready=1 -> word=16'h1FA5, cout=0, out_valid for 1 cycle, cin_fb sequence 0,0,1,0.
REQ-030 SHALL cover: last nibble (3,1) with out_ready=0 for 5 cycles -> out_valid held, word stable, cout=1, in_ready=0 throughout; drop 1 cycle after out_ready=1.
REQ-031 SHALL cover: two nibbles accepted, flush=1 with in_valid=1 -> idx=0, cin_fb=0, that nibble discarded; next 4 nibbles form a fresh word.
REQ-032 SHALL cover: rst_n low asynchronously mid-word (between clock edges) -> outputs zero immediately, in_ready=1; completion needs 4 new nibbles.
REQ-033 SHALL cover: in_valid toggling every other cycle -> only valid cycles advance idx; word correct after 4 valid nibbles.
REQ-034 SHALL cover: NIBBLES=2 build, (F,1),(F,1) -> word=8'hFF, cout=1, cin_fb=1 after first accept.
